// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box/Rcon constants and round helper functions
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef enum logic { ST_IDLE = 1'b0, ST_RUN = 1'b1 } fsm_e;

    // Byte 0x00 of the S-box sits in the top byte, byte 0xff in the bottom byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t mix_column(input word_t c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Column-major bytes: output byte 4c+r comes from input byte 4((c+r)%4)+r.
    function automatic state_t shift_rows(input state_t s);
        return {s[127:120], s[87:80],   s[47:40],   s[7:0],
                s[95:88],   s[55:48],   s[15:8],    s[103:96],
                s[63:56],   s[23:16],   s[111:104], s[71:64],
                s[31:24],   s[119:112], s[79:72],   s[39:32]};
    endfunction

endpackage

// File: rtl/aes_encrypt_core_if.sv
// rtl/aes_encrypt_core_if.sv - request/response bundle between host, AES core and ciphertext consumer
interface aes_encrypt_core_if #(
    parameter int N = 128
);
    logic         start;
    logic [127:0] in;
    logic [N-1:0] key;
    logic [127:0] out;
    logic         busy;
    logic         done;

    modport master (output start, in, key, input out, busy, done);
    modport slave  (input start, in, key, output out, busy, done);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box byte lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = sbox(byte_i);
endmodule

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128/192/256 encryptor, one round per clock
// Macro AES_ENCRYPT_CORE_RESTART_EN: start while busy aborts the block and restarts with the new data.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_encrypt_core_if.slave bus
);

`ifdef AES_ENCRYPT_CORE_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif
    localparam int NW = 4 * (Nr + 1);

    fsm_e         fsm_q;
    logic [3:0]   round_q;
    state_t       state_q, out_q;
    logic [N-1:0] key_q;
    logic         busy_q, done_q;

    state_t       sb, sr, mc, state_d;
    state_t       rk [Nr+1];
    logic         load;

    // Full key schedule from the registered key; each word lives in its own generate scope.
    for (genvar i = 0; i < NW; i++) begin : g_w
        word_t w;
        if (i < Nk) begin : g_key
            assign w = key_q[N-1-32*i -: 32];
        end else if (i % Nk == 0) begin : g_rot
            assign w = g_w[i-Nk].w ^ sub_word(rot_word(g_w[i-1].w)) ^ {RCON[i/Nk-1], 24'h0};
        end else if ((Nk > 6) && (i % Nk == 4)) begin : g_sub
            assign w = g_w[i-Nk].w ^ sub_word(g_w[i-1].w);
        end else begin : g_lin
            assign w = g_w[i-Nk].w ^ g_w[i-1].w;
        end
    end

    for (genvar r = 0; r <= Nr; r++) begin : g_rk
        assign rk[r] = {g_w[4*r].w, g_w[4*r+1].w, g_w[4*r+2].w, g_w[4*r+3].w};
    end

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (state_q[127-8*g -: 8]),
            .byte_o (sb[127-8*g -: 8])
        );
    end

    always_comb begin
        sr      = shift_rows(sb);
        mc      = {mix_column(sr[127:96]), mix_column(sr[95:64]),
                   mix_column(sr[63:32]),  mix_column(sr[31:0])};
        state_d = ((round_q == 4'(Nr)) ? sr : mc) ^ rk[round_q];
        load    = bus.start && ((fsm_q == ST_IDLE) || RESTART);
    end

    // The initial AddRoundKey uses the incoming key directly since key_q is loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                key_q   <= bus.key;
                state_q <= bus.in ^ bus.key[N-1 -: 128];
                round_q <= 4'd1;
                fsm_q   <= ST_RUN;
                busy_q  <= 1'b1;
            end else if (fsm_q == ST_RUN) begin
                if (round_q == 4'(Nr)) begin
                    out_q   <= state_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    fsm_q   <= ST_IDLE;
                    round_q <= '0;
                end else begin
                    state_q <= state_d;
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - AES-128/192/256 cores against a byte-level FIPS-197 reference model
module tb_aes_encrypt_core;

`ifdef AES_ENCRYPT_CORE_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   start_v = 3'b000;
    logic [127:0] in_v  [3];
    logic [255:0] key_v [3];
    logic [127:0] d_out [3];
    logic [2:0]   d_busy, d_done;

    aes_encrypt_core_if #(.N(128)) if0 ();
    aes_encrypt_core_if #(.N(192)) if1 ();
    aes_encrypt_core_if #(.N(256)) if2 ();

    assign if0.start = start_v[0];  assign if0.in = in_v[0];  assign if0.key = key_v[0][127:0];
    assign if1.start = start_v[1];  assign if1.in = in_v[1];  assign if1.key = key_v[1][191:0];
    assign if2.start = start_v[2];  assign if2.in = in_v[2];  assign if2.key = key_v[2];
    assign d_out[0] = if0.out;  assign d_out[1] = if1.out;  assign d_out[2] = if2.out;
    assign d_busy = {if2.busy, if1.busy, if0.busy};
    assign d_done = {if2.done, if1.done, if0.done};

    aes_encrypt_core #(128, 10, 4) u_aes128 (.clk(clk), .rst_n(rst_n), .bus(if0));
    aes_encrypt_core #(192, 12, 6) u_aes192 (.clk(clk), .rst_n(rst_n), .bus(if1));
    aes_encrypt_core #(256, 14, 8) u_aes256 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model: GF(2^8) arithmetic and byte-array AES ----------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gx(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int q = 0; q < 8; q++) begin
            if (b[q]) p = p ^ a;
            a = gx(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box built from the multiplicative inverse plus the affine map, independent of any table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
    endfunction

    function automatic logic [7:0] rc_of(input int j);
        logic [7:0] rc = 8'h01;
        for (int q = 1; q < j; q++) rc = gx(rc);
        return rc;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] key, input int nk);
        int nr;
        logic [7:0]  st [16];
        logic [7:0]  tmp [16];
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  m;
        logic [127:0] res;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc_of(i/nk), 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int n = 0; n < 16; n++) tmp[n] = sb_tab[st[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) st[4*c+row] = tmp[4*((c+row)%4)+row];
            if (r != nr) begin
                for (int n = 0; n < 16; n++) tmp[n] = st[n];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        m = gmul(8'h02, tmp[4*c+row]) ^ gmul(8'h03, tmp[4*c+(row+1)%4])
                          ^ tmp[4*c+(row+2)%4] ^ tmp[4*c+(row+3)%4];
                        st[4*c+row] = m;
                    end
            end
            for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[4*r+n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
        return res;
    endfunction

    // ---------------- cycle-level expectation: Nr-cycle countdown per core ----------------
    int           m_cnt [3] = '{0, 0, 0};
    logic [127:0] m_res [3];
    logic [127:0] m_out [3] = '{128'h0, 128'h0, 128'h0};
    logic [2:0]   m_done = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] <= 0;
                m_out[k] <= '0;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_done[k] <= 1'b0;
                if (start_v[k] && (m_cnt[k] == 0 || RESTART)) begin
                    m_cnt[k] <= 10 + 2*k;
                    m_res[k] <= aes_model(in_v[k], key_v[k], 4 + 2*k);
                end else if (m_cnt[k] != 0) begin
                    m_cnt[k] <= m_cnt[k] - 1;
                    if (m_cnt[k] == 1) begin
                        m_out[k]  <= m_res[k];
                        m_done[k] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (d_out[k] !== m_out[k] || d_busy[k] !== (m_cnt[k] != 0) || d_done[k] !== m_done[k]) begin
                n_err++;
                $display("FAIL cycle_check dut%0d t=%0t out=%h exp=%h busy=%b exp=%b done=%b exp=%b",
                         k, $time, d_out[k], m_out[k], d_busy[k], (m_cnt[k] != 0), d_done[k], m_done[k]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse(input int k, input logic [127:0] pt, input logic [255:0] key);
        in_v[k]    = pt;
        key_v[k]   = key;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (d_done[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] vin  [3];
    logic [255:0] vkey [3];
    logic [127:0] vout [3];

    initial begin
        int lat;
        int wcnt;
        logic [127:0] rin;
        logic [255:0] rkey;

        for (int k = 0; k < 3; k++) begin
            in_v[k]  = '0;
            key_v[k] = '0;
        end
        vin[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        vkey[0] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        vout[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        vin[1]  = 128'h00112233445566778899aabbccddeeff;
        vkey[1] = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
        vout[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        vin[2]  = 128'h00112233445566778899aabbccddeeff;
        vkey[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vout[2] = 128'h8ea2b7ca516745bfeafc49904b496089;

        build_sbox();
        check("model_sbox_00", 128'(sb_tab[8'h00]), 128'h63);
        check("model_sbox_53", 128'(sb_tab[8'h53]), 128'hed);
        for (int k = 0; k < 3; k++)
            check("model_fips", aes_model(vin[k], vkey[k], 4 + 2*k), vout[k]);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_out",  d_out[k], 128'h0);
            check("reset_busy", 128'(d_busy[k]), 128'h0);
            check("reset_done", 128'(d_done[k]), 128'h0);
        end
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            pulse(k, vin[k], vkey[k]);
            wait_done(k, lat);
            check("fips_latency", 128'(lat), 128'(10 + 2*k));
            check("fips_out", d_out[k], vout[k]);
        end

        // back-to-back: second start issued in the done cycle
        pulse(0, r128(), {128'h0, r128()});
        wait_done(0, lat);
        check("b2b_first_latency", 128'(lat), 128'd10);
        pulse(0, vin[0], vkey[0]);
        wait_done(0, lat);
        check("b2b_second_latency", 128'(lat), 128'd10);
        check("b2b_second_out", d_out[0], vout[0]);

        // start while busy, three cycles into the block
        pulse(0, vin[0], vkey[0]);
        repeat (3) @(negedge clk);
        rin  = r128();
        rkey = {128'h0, r128()};
        pulse(0, rin, rkey);
        wait_done(0, lat);
`ifdef AES_ENCRYPT_CORE_RESTART_EN
        check("restart_latency", 128'(lat), 128'd10);
        check("restart_out", d_out[0], aes_model(rin, rkey, 4));
`else
        check("busy_start_latency", 128'(lat), 128'd6);
        check("busy_start_out", d_out[0], vout[0]);
`endif

        // reset in the middle of a block
        pulse(0, r128(), {128'h0, r128()});
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out",  d_out[0], 128'h0);
        check("midreset_busy", 128'(d_busy[0]), 128'h0);
        check("midreset_done", 128'(d_done[0]), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse(0, vin[0], vkey[0]);
        wait_done(0, lat);
        check("post_reset_latency", 128'(lat), 128'd10);
        check("post_reset_out", d_out[0], vout[0]);

        // randomized traffic on all three cores, sometimes with a start while busy
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 3; k++) begin
                in_v[k]  = r128();
                key_v[k] = {r128(), r128()};
            end
            start_v = 3'b111;
            @(negedge clk);
            start_v = 3'b000;
            repeat ($urandom_range(0, 15)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 3; k++) begin
                    in_v[k]  = r128();
                    key_v[k] = {r128(), r128()};
                end
                start_v = 3'b111;
                @(negedge clk);
                start_v = 3'b000;
            end
            wcnt = 0;
            while (d_busy != 3'b000 && wcnt < 40) begin
                @(negedge clk);
                wcnt++;
            end
            check("drain_idle", 128'(d_busy), 128'h0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
